fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Initiator side of the instruction-memory fetch interface.
- Owns the program counter, drives the fetch address into the instruction memory, and captures the returned instruction together with its fetch exception code into the IF/ID pipeline register.
- Handles stall, branch/jump redirect, exception entry to the handler, and ERET return.
- Sits between the CP0/hazard logic and the decode stage.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- HANDLER_PC, 32'h0000_4180, exception handler entry address.
- EXC_ADEL, 5'h4, fetch address-error code reported by the instruction memory.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard stall; freezes PC and IF/ID.
- br_taken  input  1  branch/jump resolved taken in ID.
- br_target  input  32  redirect target for br_taken.
- id_is_jump  input  1  instruction currently in ID is a branch/jump; the next fetched instruction is its delay slot.
- exc_req  input  1  CP0 takes an exception or interrupt this cycle.
- eret  input  1  ERET in ID.
- epc  input  32  return address for eret.
- im_addr  output  32  fetch address to instruction memory; equals pc.
- im_instr  input  32  instruction returned combinationally by instruction memory.
- im_exc  input  5  exception code from instruction memory (0 or EXC_ADEL).
- pc  output  32  current fetch PC.
- ifid_instr  output  32  latched instruction.
- ifid_pc  output  32  PC of latched instruction.
- ifid_pc8  output  32  ifid_pc + 8, the link value.
- ifid_exc  output  5  latched fetch exception code.
- ifid_bd  output  1  latched instruction is a branch delay slot.
- ifid_valid  output  1  IF/ID holds a real instruction, not a bubble.

Behaviour:
- Reset (asynchronous, immediate):
  - pc = RESET_PC.
  - ifid_instr = 0, ifid_pc = 0, ifid_pc8 = 8.
  - ifid_exc = 0, ifid_bd = 0, ifid_valid = 0.
- im_addr = pc, combinational. The memory response is same-cycle, so fetch latency to IF/ID is 1 clock.
- Per rising edge, priority highest first:
  1. exc_req: pc ← HANDLER_PC. IF/ID flushed to bubble (instr 0, exc 0, bd 0, valid 0, pc and pc8 keep flushed-PC values). exc_req overrides stall.
  2. eret: pc ← epc. IF/ID flushed to bubble; the instruction after ERET is not a delay slot and never executes. eret overrides stall.
  3. stall: pc and all IF/ID fields hold. br_taken is ignored this cycle; the hazard unit re-asserts it after the stall.
  4. br_taken: pc ← br_target. IF/ID loads the current fetch as the delay slot: ifid_bd = id_is_jump (expected 1).
  5. Default: pc ← pc + 4, modulo 2^32, wrap allowed. IF/ID loads the current fetch with ifid_bd = id_is_jump.
- IF/ID load fields:
  - ifid_pc = pc, ifid_pc8 = pc + 8, ifid_valid = 1.
  - ifid_exc = im_exc.
  - ifid_instr = im_instr when im_exc == 0, otherwise 32'h0 (nop). A faulting fetch never injects a real opcode.
- Fetch exceptions:
  - A fetch with im_exc != 0 still advances pc normally.
  - The exception is carried in ifid_exc and resolved later by CP0, which raises exc_req.
  - Misaligned or out-of-range br_target and epc values are accepted into pc unchanged; the memory reports the fault.
- exc_req and eret asserted together: exc_req wins.
- ifid_pc8 is recomputed on every IF/ID load, never held across a flush from a stale value.

Decomposition:
- Shared package (cpu_defs):
  - RESET_PC and HANDLER_PC constants.
  - Exception code constants: EXC_INT 0, EXC_ADEL 4, EXC_ADES 5, EXC_RI 10, EXC_OV 12.
  - NOP encoding.
- Natural sub-module: ifid_reg, the IF/ID pipeline register with hold (stall), flush (bubble) and load controls.
- The PC register and next-PC priority mux stay in fetch_unit.

Test Plan:
- Reset mid-run: assert reset while pc = 0x3010 → pc = 0x3000 immediately, ifid_valid = 0. Release → ifid_pc = 0x3000 and ifid_pc = 0x3004 on successive edges.
- Stall: assert stall for 3 cycles at pc = 0x3008 → pc stays 0x3008 and IF/ID unchanged for 3 edges. Release → pc = 0x300C.
- Branch with delay slot: br_taken = 1, br_target = 0x3100, id_is_jump = 1 at pc = 0x3020 → next edge pc = 0x3100, ifid_pc = 0x3020, ifid_bd = 1, ifid_pc8 = 0x3028.
- Fetch fault: br_target = 0x3102 → pc = 0x3102; memory returns im_exc = 4 → next edge ifid_exc = 4, ifid_instr = 0, ifid_pc = 0x3102, pc = 0x3106.
- Exception vs stall vs eret: exc_req, eret and stall all asserted, epc = 0x3040 → pc = 0x4180, IF/ID bubble. Later eret alone with epc = 0x3040 → pc = 0x3040, IF/ID bubble.
- Wrap: pc forced via br_target = 0xFFFF_FFFC → next default edge pc = 0x0000_0000, ifid_pc8 = 0x0000_0004.

Source files
------------

// File: rtl/cpu_defs.sv
// cpu_defs: shared CPU constants for reset/handler vectors, exception codes and the nop encoding
package cpu_defs;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [4:0]  EXC_INT    = 5'h0;
  localparam logic [4:0]  EXC_ADEL   = 5'h4;
  localparam logic [4:0]  EXC_ADES   = 5'h5;
  localparam logic [4:0]  EXC_RI     = 5'ha;
  localparam logic [4:0]  EXC_OV     = 5'hc;
  localparam logic [31:0] NOP        = 32'h0;
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with flush (bubble), hold (stall) and load
module ifid_reg
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        hold,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instr,
  input  logic [4:0]  fetch_exc,
  input  logic        fetch_bd,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc8,
  output logic [4:0]  ifid_exc,
  output logic        ifid_bd,
  output logic        ifid_valid
);
  // a bubble still records the flushed fetch PC so pc8 never goes stale
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_instr <= NOP;
      ifid_pc    <= 32'h0;
      ifid_pc8   <= 32'h8;
      ifid_exc   <= EXC_INT;
      ifid_bd    <= 1'b0;
      ifid_valid <= 1'b0;
    end else if (flush) begin
      ifid_instr <= NOP;
      ifid_pc    <= fetch_pc;
      ifid_pc8   <= fetch_pc + 32'd8;
      ifid_exc   <= EXC_INT;
      ifid_bd    <= 1'b0;
      ifid_valid <= 1'b0;
    end else if (!hold) begin
      ifid_instr <= fetch_instr;
      ifid_pc    <= fetch_pc;
      ifid_pc8   <= fetch_pc + 32'd8;
      ifid_exc   <= fetch_exc;
      ifid_bd    <= fetch_bd;
      ifid_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, next-PC priority mux and instruction-memory fetch into IF/ID
module fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC   = cpu_defs::RESET_PC,
  parameter logic [31:0] HANDLER_PC = cpu_defs::HANDLER_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_is_jump,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  input  logic [4:0]  im_exc,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc8,
  output logic [4:0]  ifid_exc,
  output logic        ifid_bd,
  output logic        ifid_valid
);
  logic [31:0] fetch_instr;
  assign im_addr = pc;
  // a faulting fetch is replaced by a nop so no real opcode reaches decode
  assign fetch_instr = im_exc == EXC_INT ? im_instr : NOP;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= RESET_PC;
    else if (exc_req) pc <= HANDLER_PC;
    else if (eret) pc <= epc;
    else if (!stall) pc <= br_taken ? br_target : pc + 32'd4;
  end
  ifid_reg u_ifid (
    .clk         (clk),
    .reset       (reset),
    .flush       (exc_req | eret),
    .hold        (stall),
    .fetch_pc    (pc),
    .fetch_instr (fetch_instr),
    .fetch_exc   (im_exc),
    .fetch_bd    (id_is_jump),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .ifid_pc8    (ifid_pc8),
    .ifid_exc    (ifid_exc),
    .ifid_bd     (ifid_bd),
    .ifid_valid  (ifid_valid)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven vectors with a scoreboard of expected IF/ID contents
module tb_fetch_unit;
  import cpu_defs::*;
  logic        clk = 1'b0;
  logic        reset, stall, br_taken, id_is_jump, exc_req, eret;
  logic [31:0] br_target, epc, im_addr, im_instr, pc, ifid_instr, ifid_pc, ifid_pc8;
  logic [4:0]  im_exc, ifid_exc;
  logic        ifid_bd, ifid_valid;
  int          n_vec = 0;
  int          n_bad = 0;

  typedef struct {
    logic        st, br, jmp, exc, er;
    logic [31:0] tgt, ep, pc_exp;
  } vec_t;
  typedef struct {
    logic [31:0] instr, ipc;
    logic [4:0]  exc;
    logic        bd, valid;
  } exp_t;

  vec_t        tbl[18];
  exp_t        q[$];
  exp_t        m_if, e;
  logic [31:0] m_pc;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .id_is_jump(id_is_jump), .exc_req(exc_req), .eret(eret), .epc(epc), .im_addr(im_addr),
    .im_instr(im_instr), .im_exc(im_exc), .pc(pc), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc8(ifid_pc8), .ifid_exc(ifid_exc), .ifid_bd(ifid_bd), .ifid_valid(ifid_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_instr(logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  function automatic logic [4:0] mem_exc(logic [31:0] a);
    return a[1:0] != 2'b00 ? EXC_ADEL : EXC_INT;
  endfunction

  always_comb begin
    im_instr = mem_instr(im_addr);
    im_exc   = mem_exc(im_addr);
  end

  function automatic vec_t mk(logic st, br, jmp, ex, er, logic [31:0] tgt, ep, pcx);
    vec_t v;
    v.st = st; v.br = br; v.jmp = jmp; v.exc = ex; v.er = er;
    v.tgt = tgt; v.ep = ep; v.pc_exp = pcx;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; br_taken = 0; br_target = 0; id_is_jump = 0; exc_req = 0; eret = 0; epc = 0;
  endtask

  task automatic apply(vec_t v, int idx);
    exp_t nx;
    stall = v.st; br_taken = v.br; br_target = v.tgt; id_is_jump = v.jmp;
    exc_req = v.exc; eret = v.er; epc = v.ep;
    nx = m_if;
    if (v.exc || v.er) begin
      nx = '{32'h0, m_pc, 5'h0, 1'b0, 1'b0};
      m_pc = v.exc ? HANDLER_PC : v.ep;
    end else if (!v.st) begin
      nx = '{mem_exc(m_pc) != 0 ? 32'h0 : mem_instr(m_pc), m_pc, mem_exc(m_pc), v.jmp, 1'b1};
      m_pc = v.br ? v.tgt : m_pc + 32'd4;
    end
    m_if = nx;
    q.push_back(nx);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk($sformatf("v%0d pc", idx), pc, v.pc_exp);
    chk($sformatf("v%0d valid", idx), {31'h0, ifid_valid}, {31'h0, e.valid});
    chk($sformatf("v%0d bd", idx), {31'h0, ifid_bd}, {31'h0, e.bd});
    chk($sformatf("v%0d exc", idx), {27'h0, ifid_exc}, {27'h0, e.exc});
    chk($sformatf("v%0d instr", idx), ifid_instr, e.instr);
    if (e.valid) begin
      chk($sformatf("v%0d ifid_pc", idx), ifid_pc, e.ipc);
      chk($sformatf("v%0d ifid_pc8", idx), ifid_pc8, e.ipc + 32'd8);
    end
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(0,0,0,0,0, 32'h0,         32'h0,    32'h3004);
    tbl[1]  = mk(0,0,0,0,0, 32'h0,         32'h0,    32'h3008);
    tbl[2]  = mk(1,0,0,0,0, 32'h0,         32'h0,    32'h3008);
    tbl[3]  = mk(1,1,0,0,0, 32'h5000,      32'h0,    32'h3008);
    tbl[4]  = mk(1,0,0,0,0, 32'h0,         32'h0,    32'h3008);
    tbl[5]  = mk(0,0,0,0,0, 32'h0,         32'h0,    32'h300C);
    tbl[6]  = mk(0,0,0,0,0, 32'h0,         32'h0,    32'h3010);
    tbl[7]  = mk(0,1,0,0,0, 32'h3020,      32'h0,    32'h3020);
    tbl[8]  = mk(0,1,1,0,0, 32'h3100,      32'h0,    32'h3100);
    tbl[9]  = mk(0,1,1,0,0, 32'h3102,      32'h0,    32'h3102);
    tbl[10] = mk(0,0,0,0,0, 32'h0,         32'h0,    32'h3106);
    tbl[11] = mk(1,0,0,1,1, 32'h0,         32'h3040, 32'h4180);
    tbl[12] = mk(0,0,0,0,0, 32'h0,         32'h0,    32'h4184);
    tbl[13] = mk(0,0,0,0,1, 32'h0,         32'h3040, 32'h3040);
    tbl[14] = mk(1,1,0,0,0, 32'h5000,      32'h0,    32'h3040);
    tbl[15] = mk(0,1,0,0,0, 32'hFFFF_FFFC, 32'h0,    32'hFFFF_FFFC);
    tbl[16] = mk(0,0,0,0,0, 32'h0,         32'h0,    32'h0000_0000);
    tbl[17] = mk(0,0,0,0,0, 32'h0,         32'h0,    32'h0000_0004);
    clear_inputs();
    reset = 1;
    #2;
    chk("reset pc", pc, 32'h3000);
    chk("reset im_addr", im_addr, 32'h3000);
    chk("reset instr", ifid_instr, 32'h0);
    chk("reset ifid_pc", ifid_pc, 32'h0);
    chk("reset ifid_pc8", ifid_pc8, 32'h8);
    chk("reset valid", {31'h0, ifid_valid}, 32'h0);
    @(posedge clk);
    #1;
    reset = 0;
    m_pc = 32'h3000;
    m_if = '{32'h0, 32'h0, 5'h0, 1'b0, 1'b0};
    for (int i = 0; i < 18; i++) apply(tbl[i], i);
    apply(mk(0,1,0,0,0, 32'h3010, 32'h0, 32'h3010), 18);
    #2;
    reset = 1;
    #1;
    chk("midreset pc", pc, 32'h3000);
    chk("midreset valid", {31'h0, ifid_valid}, 32'h0);
    @(posedge clk);
    #1;
    reset = 0;
    @(posedge clk);
    #1;
    chk("post-reset ifid_pc 1", ifid_pc, 32'h3000);
    chk("post-reset pc 1", pc, 32'h3004);
    @(posedge clk);
    #1;
    chk("post-reset ifid_pc 2", ifid_pc, 32'h3004);
    chk("post-reset valid", {31'h0, ifid_valid}, 32'h1);
    chk("scoreboard drained", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
